// File: rtl/preproc_sched_pkg.sv
// Shared definitions for the preprocessing scheduler: FSM encoding,
// default cyclic-extension / length limits and the length legality check.
package preproc_sched_pkg;

    localparam int unsigned P_LEN_DEF   = 8;
    localparam int unsigned MAX_LEN_DEF = 1536;
    localparam int unsigned LEN_W       = 11;
    localparam int unsigned CNT_W       = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_FILL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // A block must at least cover its own cyclic extension and fit the transform.
    function automatic logic len_legal(input logic [LEN_W-1:0] len,
                                       input int unsigned      p_len,
                                       input int unsigned      max_len);
        logic [31:0] l;
        l = 32'(len);
        return (l > p_len) && (l <= max_len);
    endfunction

endpackage

// File: rtl/preproc_sched_rr_arb2.sv
// Two-way round-robin arbiter. On a tie the requester that was not granted
// last wins; the history bit moves on every accepted grant.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_idx,
    output logic       gnt_any
);

    logic last_gnt;

    // Pick the winner from the current requests and the grant history.
    always_comb begin
        gnt_any = |req;
        if (&req) begin
            gnt_idx = ~last_gnt;
        end else begin
            gnt_idx = req[1];
        end
    end

    // Remember who was granted last; requester 0 wins the first tie after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt <= 1'b1;
        end else if (take && gnt_any) begin
            last_gnt <= gnt_idx;
        end
    end

endmodule

// File: rtl/preproc_sched.sv
// Block scheduler in front of the FFT preprocessing FIFO: arbitrates two
// sample sources, streams one block into the reconstruction datapath,
// accounts for the cyclic-extension run-out and drains the FIFO downstream.
module preproc_sched
    import preproc_sched_pkg::*;
#(
    parameter int unsigned FFT_IN_WIDTH = 16,
    parameter int unsigned P_LEN        = P_LEN_DEF,
    parameter int unsigned MAX_LEN      = MAX_LEN_DEF,
    parameter int unsigned FIFO_DEPTH   = 32
) (
    input  logic                      clk_sys,
    input  logic                      rst_sys,
    input  logic                      req0_i,
    input  logic                      req1_i,
    input  logic [LEN_W-1:0]          len0_i,
    input  logic [LEN_W-1:0]          len1_i,
    output logic                      ack0_o,
    output logic                      ack1_o,
    input  logic                      src0_val_i,
    input  logic [2*FFT_IN_WIDTH-1:0] src0_data_i,
    output logic                      src0_rdy_o,
    input  logic                      src1_val_i,
    input  logic [2*FFT_IN_WIDTH-1:0] src1_data_i,
    output logic                      src1_rdy_o,
    output logic                      block_sync_o,
    output logic                      data_val_o,
    output logic [2*FFT_IN_WIDTH-1:0] data_o,
    output logic [LEN_W-1:0]          trans_len_o,
    input  logic                      fifo_empty_i,
    output logic                      fifo_re_o,
    input  logic                      dft_rdy_i,
    output logic                      sop_o,
    output logic                      eop_o,
    output logic                      err_len_o,
    output logic                      busy_o
);

    localparam int unsigned RO_N  = P_LEN + 1;
    localparam int unsigned RO_W  = $clog2(RO_N + 1);
    localparam int unsigned OCC_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [OCC_W-1:0] OCC_LIM = OCC_W'(FIFO_DEPTH - P_LEN - 2);
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(FIFO_DEPTH);
    localparam logic [RO_W-1:0]  RO_LAST = RO_W'(RO_N);
    localparam logic [CNT_W-1:0] EXT     = CNT_W'(P_LEN);

    state_t             state;
    state_t             state_nxt;
    logic               gnt_q;
    logic               arb_idx;
    logic               arb_any;
    logic               arb_take;
    logic [LEN_W-1:0]   len_sel;
    logic               len_bad;
    logic [CNT_W-1:0]   in_cnt;
    logic [CNT_W-1:0]   rd_cnt;
    logic [CNT_W-1:0]   len_ext;
    logic [CNT_W-1:0]   rd_total;
    logic [CNT_W-1:0]   rd_last;
    logic [RO_W-1:0]    ro_cnt;
    logic [OCC_W-1:0]   occ;
    logic               in_full;
    logic               src_open;
    logic               xfer;
    logic               runout;
    logic               occ_inc;

    rr_arb2 u_arb (
        .clk     (clk_sys),
        .rst     (rst_sys),
        .req     ({req1_i, req0_i}),
        .take    (arb_take),
        .gnt_idx (arb_idx),
        .gnt_any (arb_any)
    );

    assign len_sel  = gnt_q ? len1_i : len0_i;
    assign len_bad  = ~len_legal(len_sel, P_LEN, MAX_LEN);
    assign len_ext  = {1'b0, trans_len_o};
    assign rd_last  = len_ext + EXT;
    assign rd_total = len_ext + EXT + CNT_W'(1);
    assign in_full  = (in_cnt == len_ext);
    assign xfer     = (state == ST_FILL) || (state == ST_DRAIN);
    assign busy_o   = (state != ST_IDLE);

    // Source-side handshake and combinational pass-through into the datapath.
    always_comb begin
        src_open     = (state == ST_FILL) && (in_cnt < len_ext) && (occ < OCC_LIM);
        src0_rdy_o   = src_open && !gnt_q;
        src1_rdy_o   = src_open && gnt_q;
        data_val_o   = gnt_q ? (src1_val_i && src1_rdy_o) : (src0_val_i && src0_rdy_o);
        data_o       = '0;
        if (data_val_o) begin
            data_o = gnt_q ? src1_data_i : src0_data_i;
        end
        block_sync_o = data_val_o && (in_cnt == '0);
    end

    // FIFO read side and the extension run-out that follows the last sample.
    always_comb begin
        fifo_re_o = xfer && !fifo_empty_i && dft_rdy_i && (rd_cnt < rd_total);
        sop_o     = fifo_re_o && (rd_cnt == '0);
        eop_o     = fifo_re_o && (rd_cnt == rd_last);
        runout    = xfer && in_full && (ro_cnt < RO_LAST);
        occ_inc   = data_val_o || runout;
    end

    // State register.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode with grant acknowledge and length error pulses.
    always_comb begin
        state_nxt = state;
        arb_take  = 1'b0;
        ack0_o    = 1'b0;
        ack1_o    = 1'b0;
        err_len_o = 1'b0;
        case (state)
            ST_IDLE: begin
                if (arb_any) begin
                    arb_take  = 1'b1;
                    state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                ack0_o    = !gnt_q;
                ack1_o    = gnt_q;
                err_len_o = len_bad;
                state_nxt = len_bad ? ST_IDLE : ST_FILL;
            end
            ST_FILL: begin
                if (in_full) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (eop_o) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Capture the granted requester and its transform length.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            gnt_q       <= 1'b0;
            trans_len_o <= '0;
        end else begin
            if (arb_take) begin
                gnt_q <= arb_idx;
            end
            if (state == ST_GRANT) begin
                trans_len_o <= len_sel;
            end
        end
    end

    // Per-block input, run-out and read counters, cleared at each grant.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            in_cnt <= '0;
            rd_cnt <= '0;
            ro_cnt <= '0;
        end else if (state == ST_GRANT) begin
            in_cnt <= '0;
            rd_cnt <= '0;
            ro_cnt <= '0;
        end else begin
            if (data_val_o) begin
                in_cnt <= in_cnt + CNT_W'(1);
            end
            if (fifo_re_o) begin
                rd_cnt <= rd_cnt + CNT_W'(1);
            end
            if (runout) begin
                ro_cnt <= ro_cnt + RO_W'(1);
            end
        end
    end

    // FIFO occupancy: writes and reads in the same cycle cancel out.
    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            occ <= '0;
        end else if (occ_inc && !fifo_re_o && (occ != OCC_MAX)) begin
            occ <= occ + OCC_W'(1);
        end else if (!occ_inc && fifo_re_o && (occ != '0)) begin
            occ <= occ - OCC_W'(1);
        end
    end

endmodule

// File: tb/tb_preproc_sched.sv
// Directed bench for preproc_sched: models the sources and the downstream
// FIFO, counts handshakes per block and compares against hand-derived values.
module tb_preproc_sched;

    localparam int unsigned W  = 16;
    localparam int unsigned PL = 8;

    logic            clk_sys = 1'b0;
    logic            rst_sys;
    logic            req0_i, req1_i;
    logic [10:0]     len0_i, len1_i;
    logic            ack0_o, ack1_o;
    logic            src0_val_i, src1_val_i;
    logic [2*W-1:0]  src0_data_i, src1_data_i;
    logic            src0_rdy_o, src1_rdy_o;
    logic            block_sync_o, data_val_o;
    logic [2*W-1:0]  data_o;
    logic [10:0]     trans_len_o;
    logic            fifo_empty_i, fifo_re_o, dft_rdy_i;
    logic            sop_o, eop_o, err_len_o, busy_o;

    logic [15:0] k0, k1;
    int n_checks, n_errors;
    int cyc, n_ack0, n_ack1, n_err, n_err_ack, n_dv, n_sync, n_sync_first;
    int n_re, n_eop, n_spur, n_data_bad, sop_idx, eop_idx, first_ack;
    int ack1_cyc, eop_cyc, busy_after_eop, busy_after_ack;
    int fm, max_fm, blk_dv, cur_len, act_src, e0;
    logic prev_eop, prev_ack;

    always #5 clk_sys = ~clk_sys;

    assign src0_data_i = {k0, k0 ^ 16'h5A5A};
    assign src1_data_i = {k1 ^ 16'h0F0F, k1};

    preproc_sched #(
        .FFT_IN_WIDTH (W),
        .P_LEN        (PL),
        .MAX_LEN      (1536),
        .FIFO_DEPTH   (32)
    ) dut (
        .clk_sys      (clk_sys),
        .rst_sys      (rst_sys),
        .req0_i       (req0_i),
        .req1_i       (req1_i),
        .len0_i       (len0_i),
        .len1_i       (len1_i),
        .ack0_o       (ack0_o),
        .ack1_o       (ack1_o),
        .src0_val_i   (src0_val_i),
        .src0_data_i  (src0_data_i),
        .src0_rdy_o   (src0_rdy_o),
        .src1_val_i   (src1_val_i),
        .src1_data_i  (src1_data_i),
        .src1_rdy_o   (src1_rdy_o),
        .block_sync_o (block_sync_o),
        .data_val_o   (data_val_o),
        .data_o       (data_o),
        .trans_len_o  (trans_len_o),
        .fifo_empty_i (fifo_empty_i),
        .fifo_re_o    (fifo_re_o),
        .dft_rdy_i    (dft_rdy_i),
        .sop_o        (sop_o),
        .eop_o        (eop_o),
        .err_len_o    (err_len_o),
        .busy_o       (busy_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        n_ack0 = 0; n_ack1 = 0; n_err = 0; n_err_ack = 0; n_dv = 0; n_sync = 0;
        n_sync_first = 0; n_re = 0; n_eop = 0; n_spur = 0; n_data_bad = 0;
        sop_idx = -1; eop_idx = -1; first_ack = -1; ack1_cyc = -1; eop_cyc = -1;
        busy_after_eop = -1; busy_after_ack = -1; max_fm = fm;
    endtask

    // One clock: sample outputs at the falling edge, update environment after the rising edge.
    task automatic step();
        logic a0, a1, acc0, acc1;
        int inc, dec;
        logic [2*W-1:0] exp_d;
        a0 = 1'b0; a1 = 1'b0; acc0 = 1'b0; acc1 = 1'b0; inc = 0; dec = 0;
        @(negedge clk_sys);
        if (prev_ack) busy_after_ack = int'(busy_o);
        if (prev_eop) busy_after_eop = int'(busy_o);
        prev_ack = ack0_o | ack1_o;
        prev_eop = eop_o;
        if (ack0_o) begin
            a0 = 1'b1; n_ack0++; act_src = 0; cur_len = int'(len0_i); blk_dv = 0;
            if (first_ack < 0) first_ack = 0;
        end
        if (ack1_o) begin
            a1 = 1'b1; n_ack1++; act_src = 1; cur_len = int'(len1_i); blk_dv = 0;
            ack1_cyc = cyc;
            if (first_ack < 0) first_ack = 1;
        end
        if (err_len_o) begin
            n_err++;
            if (ack0_o || ack1_o) n_err_ack++;
        end
        if (data_val_o) begin
            exp_d = (act_src == 1) ? {k1 ^ 16'h0F0F, k1} : {k0, k0 ^ 16'h5A5A};
            if (data_o !== exp_d) n_data_bad++;
            if (block_sync_o) begin
                n_sync++;
                if (blk_dv == 0) n_sync_first++;
            end
            n_dv++; blk_dv++; inc = 1;
            if (blk_dv == cur_len) inc = 1 + PL + 1;
            if (act_src == 1) acc1 = 1'b1; else acc0 = 1'b1;
        end else if (block_sync_o) begin
            n_spur++;
        end
        if (fifo_re_o) begin
            n_re++; dec = 1;
            if (sop_o) sop_idx = n_re;
            if (eop_o) begin
                eop_idx = n_re; n_eop++; eop_cyc = cyc;
            end
        end else if (sop_o || eop_o) begin
            n_spur++;
        end
        @(posedge clk_sys);
        #1;
        cyc++;
        fm = fm + inc - dec;
        if (fm > max_fm) max_fm = fm;
        fifo_empty_i = (fm == 0);
        if (acc0) k0++;
        if (acc1) k1++;
        if (a0) req0_i = 1'b0;
        if (a1) req1_i = 1'b0;
    endtask

    task automatic wait_eop(input int n, input int budget);
        for (int c = 0; c < budget && n_eop < n; c++) step();
    endtask

    task automatic do_reset();
        rst_sys = 1'b1;
        req0_i = 1'b0; req1_i = 1'b0;
        fm = 0; fifo_empty_i = 1'b1;
        prev_eop = 1'b0; prev_ack = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        rst_sys = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_errors = 0; cyc = 0; k0 = '0; k1 = '0;
        fm = 0; blk_dv = 0; cur_len = 0; act_src = 0;
        len0_i = '0; len1_i = '0; src0_val_i = 1'b1; src1_val_i = 1'b1;
        dft_rdy_i = 1'b1;
        do_reset();

        // Reset state
        check("rst_busy", int'(busy_o), 0);
        check("rst_len", int'(trans_len_o), 0);
        check("rst_outs", int'({ack0_o, ack1_o, src0_rdy_o, src1_rdy_o, data_val_o,
                                fifo_re_o, sop_o, eop_o, err_len_o}), 0);

        // Single block from requester 0, len 12
        clr();
        req0_i = 1'b1; len0_i = 11'd12;
        wait_eop(1, 200);
        step(); step();
        check("t1_ack0", n_ack0, 1);
        check("t1_ack1", n_ack1, 0);
        check("t1_dv", n_dv, 12);
        check("t1_sync", n_sync, 1);
        check("t1_sync_first", n_sync_first, 1);
        check("t1_reads", n_re, 21);
        check("t1_sop_idx", sop_idx, 1);
        check("t1_eop_idx", eop_idx, 21);
        check("t1_len", int'(trans_len_o), 12);
        check("t1_data", n_data_bad, 0);
        check("t1_err", n_err, 0);
        check("t1_spur", n_spur, 0);
        check("t1_idle", int'(busy_o), 0);

        // Simultaneous requests after reset: 0 first, 1 right after block 0 ends
        do_reset();
        clr();
        req0_i = 1'b1; len0_i = 11'd12;
        req1_i = 1'b1; len1_i = 11'd10;
        wait_eop(1, 200);
        e0 = eop_cyc;
        step();
        check("t2_busy_after_eop", busy_after_eop, 0);
        wait_eop(2, 200);
        step();
        check("t2_first_ack", first_ack, 0);
        check("t2_ack1_lat", ack1_cyc - e0, 2);
        check("t2_acks", n_ack0 + n_ack1, 2);
        check("t2_dv", n_dv, 22);
        check("t2_reads", n_re, 40);
        check("t2_eop_idx", eop_idx, 40);
        check("t2_len", int'(trans_len_o), 10);
        check("t2_data", n_data_bad, 0);

        // Too-short length from requester 1
        clr();
        req1_i = 1'b1; len1_i = 11'd5;
        repeat (10) step();
        check("t3_ack1", n_ack1, 1);
        check("t3_err", n_err, 1);
        check("t3_err_with_ack", n_err_ack, 1);
        check("t3_dv", n_dv, 0);
        check("t3_next_idle", busy_after_ack, 0);
        check("t3_len", int'(trans_len_o), 5);
        check("t3_reads", n_re, 0);

        // Too-long length
        clr();
        req0_i = 1'b1; len0_i = 11'd1537;
        repeat (10) step();
        check("t3b_ack0", n_ack0, 1);
        check("t3b_err", n_err, 1);
        check("t3b_dv", n_dv, 0);

        // Shortest legal length P_LEN+1
        clr();
        req0_i = 1'b1; len0_i = 11'd9;
        wait_eop(1, 200);
        step();
        check("t3c_err", n_err, 0);
        check("t3c_dv", n_dv, 9);
        check("t3c_reads", n_re, 18);
        check("t3c_eop_idx", eop_idx, 18);

        // Downstream stalled: source throttled at occupancy 22, then full drain
        clr();
        dft_rdy_i = 1'b0;
        req0_i = 1'b1; len0_i = 11'd64;
        repeat (60) step();
        check("t4_dv_stall", n_dv, 22);
        check("t4_rdy_low", int'(src0_rdy_o), 0);
        check("t4_reads_stall", n_re, 0);
        dft_rdy_i = 1'b1;
        wait_eop(1, 400);
        step();
        check("t4_dv", n_dv, 64);
        check("t4_reads", n_re, 73);
        check("t4_sop_idx", sop_idx, 1);
        check("t4_eop_idx", eop_idx, 73);
        check("t4_no_overflow", int'(max_fm <= 32), 1);
        check("t4_data", n_data_bad, 0);

        // Reset in the middle of a block, then a clean block
        clr();
        req0_i = 1'b1; len0_i = 11'd64;
        for (int c = 0; c < 200 && n_dv < 30; c++) step();
        check("t5_dv_before", n_dv, 30);
        check("t5_busy_before", int'(busy_o), 1);
        rst_sys = 1'b1;
        #1;
        check("t5_outs_zero", int'({ack0_o, ack1_o, src0_rdy_o, src1_rdy_o, block_sync_o,
                                    data_val_o, fifo_re_o, sop_o, eop_o, err_len_o, busy_o}), 0);
        check("t5_len_zero", int'(trans_len_o), 0);
        check("t5_data_zero", int'(data_o != '0), 0);
        do_reset();
        check("t5_no_eop", n_eop, 0);
        clr();
        req0_i = 1'b1; len0_i = 11'd16;
        wait_eop(1, 200);
        step();
        check("t5_dv", n_dv, 16);
        check("t5_reads", n_re, 25);
        check("t5_eop", n_eop, 1);
        check("t5_eop_idx", eop_idx, 25);
        check("t5_data", n_data_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/preproc_sched.md
PREPROC_SCHED -- requirements
Module: preproc_sched

Interface
REQ-001 SHALL have parameter FFT_IN_WIDTH, default 16, width of each real/imag sample.
REQ-002 SHALL have parameter P_LEN, default 8, cyclic extension index; each block appends P_LEN+1 words.
REQ-003 SHALL have parameter MAX_LEN, default 1536, largest legal transform length.
REQ-004 SHALL have parameter FIFO_DEPTH, default 32, depth of the downstream preprocessing FIFO.
REQ-005 SHALL have port clk_sys, input, 1, the single clock.
REQ-006 SHALL have port rst_sys, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port reqN_i (N=0,1), input, 1, block request; held high until ackN_o.
REQ-008 SHALL have port lenN_i, input, 11, transform length for requester N; sampled with ackN_o.
REQ-009 SHALL have port ackN_o, output, 1, one-cycle request acknowledge.
REQ-010 SHALL have port srcN_val_i, input, 1, requester N sample valid.
REQ-011 SHALL have port srcN_data_i, input, 2*FFT_IN_WIDTH, {real,imag}.
REQ-012 SHALL have port srcN_rdy_o, output, 1, requester N sample ready.
REQ-013 SHALL have port block_sync_o, output, 1, first-sample marker to the reconstruction datapath.
REQ-014 SHALL have port data_val_o, output, 1, sample valid to the datapath.
REQ-015 SHALL have port data_o, output, 2*FFT_IN_WIDTH, sample to the datapath.
REQ-016 SHALL have port trans_len_o, output, 11, length of the active block.
REQ-017 SHALL have ports fifo_empty_i (input, 1) and fifo_re_o (output, 1), FIFO empty flag and read enable.
REQ-018 SHALL have port dft_rdy_i, input, 1, downstream can accept a word this cycle.
REQ-019 SHALL have ports sop_o and eop_o, output, 1 each, aligned with first/last fifo_re_o of a block.
REQ-020 SHALL have ports err_len_o (output, 1, illegal-length pulse) and busy_o (output, 1, state != IDLE).

Function
REQ-021 SHALL implement FSM IDLE -> GRANT -> FILL -> DRAIN -> IDLE, one block at a time.
REQ-022 IDLE SHALL go to GRANT when any reqN_i is high; arbitration is round-robin with last_gnt.
REQ-023 With both requests high, the requester != last_gnt SHALL win; last_gnt SHALL update on every grant.
REQ-024 GRANT SHALL last one cycle: pulse ackN_o and latch lenN_i into trans_len_o.
REQ-025 If the latched length is < P_LEN+1 or > MAX_LEN, err_len_o SHALL pulse with ackN_o and the next state SHALL be IDLE.
REQ-026 In FILL, srcN_rdy_o SHALL be high only for the granted N, only while in_cnt < len, and only while occ < FIFO_DEPTH-P_LEN-2.
REQ-027 Each srcN_val_i & srcN_rdy_o SHALL drive data_val_o=1 with data_o=srcN_data_i in the same cycle (combinational pass-through), then increment in_cnt.
REQ-028 block_sync_o SHALL equal data_val_o & (in_cnt==0).
REQ-029 FILL SHALL go to DRAIN in the cycle after in_cnt reaches len; data_val_o SHALL stay 0 until the next FILL.
REQ-030 fifo_re_o SHALL equal ~fifo_empty_i & dft_rdy_i & (rd_cnt < len+P_LEN+1) in FILL or DRAIN.
REQ-031 occ SHALL be 0..FIFO_DEPTH: +1 per data_val_o, +1 per run-out word (P_LEN+1 total after the last sample), -1 per fifo_re_o; simultaneous +/- SHALL net.
REQ-032 sop_o SHALL pulse with rd_cnt==0; eop_o SHALL pulse with rd_cnt==len+P_LEN.
REQ-033 DRAIN SHALL return to IDLE the cycle after eop_o; a request pending in that cycle SHALL be granted next.
REQ-034 Requests arriving outside IDLE SHALL be held off, not dropped; in_cnt and rd_cnt are 12 bits and clear in GRANT.

Reset
REQ-035 rst_sys SHALL asynchronously force IDLE, clear all counters and occ, set last_gnt=1, and drive all outputs to 0.
REQ-036 Reset mid-block SHALL discard the block without emitting eop_o.

Structure
REQ-037 FSM state encoding, P_LEN and MAX_LEN defaults SHALL live in the shared preprocessing package/macros file.
REQ-038 A sub-module rr_arb2 (2-way round-robin arbiter) SHALL implement the arbitration.

Verification
REQ-039 req0 only, len0=12, P_LEN=8, dft_rdy=1 -> ack0 pulse; 12 data_val_o with block_sync_o on the first; 21 fifo_re_o; sop/eop at reads 1/21.
REQ-040 req0 and req1 in the same cycle after reset -> ack0 first; req1 granted in the cycle after block 0 eop_o.
REQ-041 len1=5 (< P_LEN+1) -> ack1 and err_len_o in the same cycle; no data_val_o; next state IDLE.
REQ-042 dft_rdy_i=0 during FILL, len=64 -> src rdy drops once occ reaches 22; no FIFO overflow; all 73 words read after dft_rdy_i=1.
REQ-043 rst_sys asserted at in_cnt=30 -> outputs 0 immediately; a new req0 with len0=16 then runs cleanly with 25 reads.
